// File: rtl/e203_ifu_flush_rsp_pkg.sv
// Shared definitions for the IFU flush responder: default widths and FSM state encoding.
package e203_ifu_flush_rsp_pkg;

  localparam int PC_SIZE_DEF = 32;
  localparam int OUTS_W_DEF  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } flush_state_e;

endpackage

// File: rtl/e203_ifu_flush_cnt.sv
// Up/down counter with parallel load; overflow and underflow are flagged by assertions.
module e203_ifu_flush_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over inc/dec, so a reload never double counts the same-cycle events.
  assign cnt_d = load_i ? load_val_i : cnt_q + W'(inc_i) - W'(dec_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

  cnt_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (!load_i && inc_i && !dec_i) |-> (cnt_q != '1));

  cnt_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (!load_i && dec_i && !inc_i) |-> (cnt_q != '0));

endmodule

// File: rtl/e203_ifu_flush_rsp.sv
// IFU responder for commit flushes: acks the flush, registers the redirect PC and
// swallows fetch responses that belong to instructions fetched before the flush.
module e203_ifu_flush_rsp
  import e203_ifu_flush_rsp_pkg::*;
#(
  parameter int PC_SIZE      = PC_SIZE_DEF,
  parameter int OUTS_W       = OUTS_W_DEF,
  parameter int TIMING_BOOST = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  input  logic [PC_SIZE-1:0] flush_add_op1,
  input  logic [PC_SIZE-1:0] flush_add_op2,
  input  logic [PC_SIZE-1:0] flush_pc,
  output logic               flush_ack,
  input  logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  input  logic               mem_rsp_valid,
  output logic               mem_rsp_ready,
  output logic               ifu_rsp_valid,
  input  logic               ifu_rsp_ready,
  output logic               redirect_valid,
  output logic [PC_SIZE-1:0] redirect_pc,
  input  logic               redirect_ready,
  output logic               flush_busy
);

  logic               req_hsk;
  logic               rsp_hsk;
  logic               drop;
  logic [OUTS_W-1:0]  out_cnt;
  logic [OUTS_W-1:0]  out_cnt_nxt;
  logic [OUTS_W-1:0]  drain_cnt;
  logic [PC_SIZE-1:0] flush_target;
  logic [PC_SIZE-1:0] redirect_pc_q;
  flush_state_e       state_q;

  assign req_hsk = ifu_req_valid & ifu_req_ready;

  // A request stalled mid-handshake would be lost from the drain count, so hold off the ack.
  assign flush_ack = flush_req & ~(ifu_req_valid & ~ifu_req_ready);

  assign drop          = (drain_cnt != '0) | flush_ack;
  assign mem_rsp_ready = drop | ifu_rsp_ready;
  assign rsp_hsk       = mem_rsp_valid & mem_rsp_ready;
  assign ifu_rsp_valid = mem_rsp_valid & ~drop;

  assign out_cnt_nxt  = out_cnt + OUTS_W'(req_hsk) - OUTS_W'(rsp_hsk);
  assign flush_target = (TIMING_BOOST != 0) ? flush_pc : flush_add_op1 + flush_add_op2;

  e203_ifu_flush_cnt #(.W(OUTS_W)) u_out_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (req_hsk),
    .dec_i      (rsp_hsk),
    .cnt_o      (out_cnt)
  );

  // Each ack reloads from everything in flight, subsuming any older drain.
  e203_ifu_flush_cnt #(.W(OUTS_W)) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (flush_ack),
    .load_val_i (out_cnt_nxt),
    .inc_i      (req_hsk & (state_q == HOLD)),
    .dec_i      (rsp_hsk & drop),
    .cnt_o      (drain_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
    end else if (flush_ack) begin
      state_q       <= HOLD;
      redirect_pc_q <= flush_target;
    end else if ((state_q == HOLD) && redirect_ready) begin
      state_q       <= IDLE;
    end
  end

  assign redirect_valid = (state_q == HOLD);
  assign redirect_pc    = redirect_pc_q;
  assign flush_busy     = (state_q == HOLD) | (drain_cnt != '0);

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Self-checking bench for e203_ifu_flush_rsp: directed scenarios plus random traffic,
// compared against a queue-of-fetches reference model.
module tb_e203_ifu_flush_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req;
  logic [31:0] flush_add_op1;
  logic [31:0] flush_add_op2;
  logic [31:0] flush_pc;
  logic        flush_ack;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush_busy;

  int checks = 0;
  int errors = 0;
  int dut_hs = 0;

  // Reference model: one entry per fetch in flight, oldest first; 1 = belongs to a flushed stream.
  bit          stale_q[$];
  logic        pending;
  logic [31:0] m_pc;
  logic        ack;

  e203_ifu_flush_rsp dut (
    .clk            (clk),
    .rst            (rst),
    .flush_req      (flush_req),
    .flush_add_op1  (flush_add_op1),
    .flush_add_op2  (flush_add_op2),
    .flush_pc       (flush_pc),
    .flush_ack      (flush_ack),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .ifu_rsp_valid  (ifu_rsp_valid),
    .ifu_rsp_ready  (ifu_rsp_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush_busy     (flush_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int stale_cnt();
    int n = 0;
    foreach (stale_q[i]) n += int'(stale_q[i]);
    return n;
  endfunction

  // One clock: drive at negedge, check outputs 1ns later, advance the model at posedge.
  task automatic step(input logic fr, input logic [31:0] o1, input logic [31:0] o2,
                      input logic rv, input logic rr, input logic mv, input logic ir,
                      input logic rdr, output logic acked);
    logic exp_ack, exp_drop, exp_mrdy, req, rsp;
    @(negedge clk);
    flush_req      = fr;
    flush_add_op1  = o1;
    flush_add_op2  = o2;
    flush_pc       = $urandom;
    ifu_req_valid  = rv;
    ifu_req_ready  = rr;
    mem_rsp_valid  = mv;
    ifu_rsp_ready  = ir;
    redirect_ready = rdr;
    #1;
    exp_ack  = fr & ~(rv & ~rr);
    exp_drop = (stale_cnt() != 0) | exp_ack;
    exp_mrdy = exp_drop | ir;
    check("flush_ack",      flush_ack,      exp_ack);
    check("ifu_rsp_valid",  ifu_rsp_valid,  mv & ~exp_drop);
    check("mem_rsp_ready",  mem_rsp_ready,  exp_mrdy);
    check("redirect_valid", redirect_valid, pending);
    check("redirect_pc",    redirect_pc,    m_pc);
    check("flush_busy",     flush_busy,     pending | (stale_cnt() != 0));
    if (redirect_valid && rdr) dut_hs++;
    acked = exp_ack;
    req = rv & rr;
    rsp = mv & exp_mrdy;
    @(posedge clk);
    if (exp_ack) begin
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      if (req) stale_q.push_back(1'b1);
      pending = 1'b1;
      m_pc    = o1 + o2;
    end else begin
      if (req) stale_q.push_back(pending);
      if (pending && rdr) pending = 1'b0;
    end
    if (rsp && stale_q.size() > 0) void'(stale_q.pop_front());
  endtask

  task automatic idle_step(input logic rdr);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, rdr, ack);
  endtask

  task automatic fetch_step();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ack);
  endtask

  task automatic rsp_step();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ack);
  endtask

  initial begin
    logic        fr_hold;
    logic [31:0] r_op1, r_op2;
    int          hs0;

    rst = 1'b1;
    flush_req = 1'b0; flush_add_op1 = '0; flush_add_op2 = '0; flush_pc = '0;
    ifu_req_valid = 1'b0; ifu_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    ifu_rsp_ready = 1'b0; redirect_ready = 1'b0;
    pending = 1'b0; m_pc = '0;
    #1;
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_redirect_pc",    redirect_pc,    32'h0);
    check("rst_flush_busy",     flush_busy,     1'b0);
    check("rst_flush_ack",      flush_ack,      1'b0);
    check("rst_ifu_rsp_valid",  ifu_rsp_valid,  1'b0);
    check("rst_mem_rsp_ready",  mem_rsp_ready,  1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle flush: ack same cycle, redirect next cycle, back to idle after redirect_ready.
    step(1'b1, 32'h8000_0100, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ack);
    #1;
    check("idle_redirect_valid", redirect_valid, 1'b1);
    check("idle_redirect_pc",    redirect_pc,    32'h8000_0120);
    idle_step(1'b1);
    idle_step(1'b0);

    // Drain: two fetches in flight at the flush are swallowed, the fresh third is forwarded.
    fetch_step();
    fetch_step();
    step(1'b1, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ack);
    idle_step(1'b1);
    fetch_step();
    repeat (3) rsp_step();
    idle_step(1'b0);

    // Stalled request: ack waits for the handshake, and that fetch is drained.
    step(1'b1, 32'h2000, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ack);
    step(1'b1, 32'h2000, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ack);
    idle_step(1'b1);
    fetch_step();
    repeat (2) rsp_step();
    idle_step(1'b0);

    // Double flush while HOLD and not ready: newest target wins, one handshake.
    hs0 = dut_hs;
    step(1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ack);
    idle_step(1'b0);
    step(1'b1, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ack);
    #1;
    check("dbl_redirect_pc", redirect_pc, 32'h200);
    idle_step(1'b1);
    idle_step(1'b1);
    idle_step(1'b1);
    check("dbl_handshakes", 32'(dut_hs - hs0), 32'd1);

    // Wrap of the target adder.
    step(1'b1, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ack);
    #1;
    check("wrap_redirect_pc", redirect_pc, 32'h4);
    idle_step(1'b1);

    // Asynchronous reset during HOLD with two fetches being drained.
    fetch_step();
    fetch_step();
    step(1'b1, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ack);
    #1;
    check("pre_rst_flush_busy", flush_busy, 1'b1);
    @(negedge clk);
    flush_req = 1'b0; ifu_req_valid = 1'b0; mem_rsp_valid = 1'b0; redirect_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_redirect_valid", redirect_valid, 1'b0);
    check("async_rst_flush_busy",     flush_busy,     1'b0);
    check("async_rst_redirect_pc",    redirect_pc,    32'h0);
    stale_q.delete();
    pending = 1'b0;
    m_pc    = '0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic; flush_req is held with stable operands until acked.
    fr_hold = 1'b0;
    r_op1   = '0;
    r_op2   = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic rv, rr, mv, ir, rdr;
      if (!fr_hold && $urandom_range(0, 9) == 0) begin
        fr_hold = 1'b1;
        r_op1   = $urandom;
        r_op2   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 64);
      end
      rv  = 1'($urandom_range(0, 1));
      rr  = (stale_q.size() < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      mv  = (stale_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      ir  = ($urandom_range(0, 3) != 0);
      rdr = 1'($urandom_range(0, 1));
      step(fr_hold, r_op1, r_op2, rv, rr, mv, ir, rdr, ack);
      if (ack) fr_hold = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
